// File: rtl/puf_majority_collector.sv
// puf_majority_collector: gathers num_reads raw PUF readouts word by word,
// keeps a per-bit ones count, forms a temporal-majority signature and drives
// the error-correction stage through one provision or correct transaction.
module puf_majority_collector #(
  parameter int puf_sig_length = 256,
  parameter int word_w         = 32,
  parameter int num_reads      = 3,
  parameter int ipid_N         = 16,
  parameter int ack_timeout    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [$clog2(ipid_N)-1:0]   ipid_number,
  output logic                        puf_req,
  input  logic [word_w-1:0]           puf_word,
  input  logic                        puf_word_valid,
  output logic [1:0]                  pcm_instruction,
  output logic [puf_sig_length-1:0]   pcm_puf_in,
  output logic                        pcm_puf_in_valid,
  output logic [$clog2(ipid_N)-1:0]   pcm_ipid_number,
  input  logic                        pcm_S_c,
  input  logic [puf_sig_length-1:0]   pcm_puf_out,
  input  logic                        pcm_puf_out_valid,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [puf_sig_length-1:0]   sig_result
);

  localparam int NW  = puf_sig_length / word_w;
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RIW = (num_reads > 1) ? $clog2(num_reads) : 1;
  localparam int CW  = $clog2(num_reads + 1);
  localparam int TW  = $clog2(ack_timeout + 1);
  localparam int IW  = $clog2(ipid_N);

  localparam logic [1:0] OP_PROV = 2'b01;
  localparam logic [1:0] OP_CORR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VOTE    = 3'd2,
    ISSUE   = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                    state_q, state_d;
  logic [1:0]                op_q, op_d;
  logic [IW-1:0]             id_q, id_d;
  logic [CW-1:0]             cnt_q [puf_sig_length];
  logic [CW-1:0]             cnt_d [puf_sig_length];
  logic [WIW-1:0]            widx_q, widx_d;
  logic [RIW-1:0]            ridx_q, ridx_d;
  logic [TW-1:0]             tmo_q, tmo_d;
  logic                      puf_req_q, puf_req_d;
  logic [1:0]                instr_q, instr_d;
  logic [puf_sig_length-1:0] puf_in_q, puf_in_d;
  logic                      valid_q, valid_d;
  logic [IW-1:0]             ipid_q, ipid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [puf_sig_length-1:0] sig_result_q, sig_result_d;
  logic [puf_sig_length-1:0] vote;
  logic                      ack_ok;

  // Majority decision per bit: strictly more than half the reads were ones.
  always_comb begin
    vote = '0;
    for (int i = 0; i < puf_sig_length; i++) begin
      vote[i] = (cnt_q[i] > CW'(num_reads / 2));
    end
  end

  // Only the acknowledge that matches the latched operation completes ISSUE.
  assign ack_ok = ((op_q == OP_PROV) && pcm_S_c) ||
                  ((op_q == OP_CORR) && pcm_puf_out_valid);

  // Next-state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    ridx_d       = ridx_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    puf_in_d     = puf_in_q;
    ipid_d       = ipid_q;
    sig_result_d = sig_result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if ((op == OP_PROV) || (op == OP_CORR)) begin
            op_d   = op;
            id_d   = ipid_number;
            widx_d = '0;
            ridx_d = '0;
            err_d  = 1'b0;
            for (int i = 0; i < puf_sig_length; i++) begin
              cnt_d[i] = '0;
            end
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (puf_word_valid) begin
          for (int w = 0; w < NW; w++) begin
            for (int b = 0; b < word_w; b++) begin
              if (widx_q == WIW'(w)) begin
                cnt_d[w*word_w+b] = cnt_q[w*word_w+b] + CW'(puf_word[b]);
              end
            end
          end
          if (widx_q == WIW'(NW - 1)) begin
            widx_d = '0;
            if (ridx_q == RIW'(num_reads - 1)) begin
              state_d = VOTE;
            end else begin
              ridx_d = ridx_q + RIW'(1);
            end
          end else begin
            widx_d = widx_q + WIW'(1);
          end
        end
      end
      VOTE: begin
        puf_in_d = vote;
        ipid_d   = id_q;
        tmo_d    = '0;
        state_d  = ISSUE;
      end
      ISSUE: begin
        if (ack_ok) begin
          if (op_q == OP_CORR) begin
            sig_result_d = pcm_puf_out;
          end
          state_d = RELEASE;
        end else if (tmo_q == TW'(ack_timeout - 1)) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RELEASE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs follow the state being entered so they are registered in step.
    puf_req_d = (state_d == COLLECT);
    instr_d   = (state_d == ISSUE) ? op_q : 2'b00;
    valid_d   = (state_d == ISSUE) || (state_d == RELEASE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

  // State, counters and registered outputs; reset discards any collection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      id_q         <= '0;
      widx_q       <= '0;
      ridx_q       <= '0;
      tmo_q        <= '0;
      puf_req_q    <= 1'b0;
      instr_q      <= 2'b00;
      puf_in_q     <= '0;
      valid_q      <= 1'b0;
      ipid_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sig_result_q <= '0;
      for (int i = 0; i < puf_sig_length; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      id_q         <= id_d;
      widx_q       <= widx_d;
      ridx_q       <= ridx_d;
      tmo_q        <= tmo_d;
      puf_req_q    <= puf_req_d;
      instr_q      <= instr_d;
      puf_in_q     <= puf_in_d;
      valid_q      <= valid_d;
      ipid_q       <= ipid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sig_result_q <= sig_result_d;
      cnt_q        <= cnt_d;
    end
  end

  assign puf_req          = puf_req_q;
  assign pcm_instruction  = instr_q;
  assign pcm_puf_in       = puf_in_q;
  assign pcm_puf_in_valid = valid_q;
  assign pcm_ipid_number  = ipid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign sig_result       = sig_result_q;

endmodule

// File: tb/tb_puf_majority_collector.sv
// Testbench for puf_majority_collector: directed transactions with a
// per-cycle expected-output timeline and a bitwise majority model.
module tb_puf_majority_collector;

  localparam int SIG = 256;
  localparam int WW  = 32;
  localparam int NW  = SIG / WW;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [1:0]     op;
  logic [3:0]     ipid_number;
  logic           puf_req;
  logic [WW-1:0]  puf_word;
  logic           puf_word_valid;
  logic [1:0]     pcm_instruction;
  logic [SIG-1:0] pcm_puf_in;
  logic           pcm_puf_in_valid;
  logic [3:0]     pcm_ipid_number;
  logic           pcm_S_c;
  logic [SIG-1:0] pcm_puf_out;
  logic           pcm_puf_out_valid;
  logic           busy;
  logic           done;
  logic           err;
  logic [SIG-1:0] sig_result;

  puf_majority_collector #(
    .puf_sig_length(SIG), .word_w(WW), .num_reads(3), .ipid_N(16), .ack_timeout(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ipid_number(ipid_number),
    .puf_req(puf_req), .puf_word(puf_word), .puf_word_valid(puf_word_valid),
    .pcm_instruction(pcm_instruction), .pcm_puf_in(pcm_puf_in),
    .pcm_puf_in_valid(pcm_puf_in_valid), .pcm_ipid_number(pcm_ipid_number),
    .pcm_S_c(pcm_S_c), .pcm_puf_out(pcm_puf_out), .pcm_puf_out_valid(pcm_puf_out_valid),
    .busy(busy), .done(done), .err(err), .sig_result(sig_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected output timeline, updated by the driver just after each edge.
  logic           chk_en = 1'b0;
  logic           exp_busy, exp_req, exp_valid, exp_done, exp_err;
  logic [1:0]     exp_instr;
  logic [SIG-1:0] exp_puf_in, exp_sig;
  logic [3:0]     exp_ipid;

  localparam logic [SIG-1:0] A5 = {8{32'hA5A5A5A5}};
  localparam logic [SIG-1:0] X  = {8{32'h0F0F0F0F}};
  localparam logic [SIG-1:0] Y  = {8{32'hFFFF0000}};
  localparam logic [SIG-1:0] P  = 256'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [SIG-1:0] R1 = 256'h12345678_9ABCDEF0_0FEDCBA9_87654321_DEADBEEF_CAFEF00D_13579BDF_2468ACE0;
  localparam logic [SIG-1:0] R2 = 256'hFEDCBA98_76543210_01234567_89ABCDEF_55AA55AA_33CC33CC_0F0F1E1E_77778888;

  task automatic chk(input string name, input logic [SIG-1:0] act, input logic [SIG-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: compare all outputs against the expected timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {255'd0, busy}, {255'd0, exp_busy});
      chk("puf_req", {255'd0, puf_req}, {255'd0, exp_req});
      chk("instr", {254'd0, pcm_instruction}, {254'd0, exp_instr});
      chk("puf_in_valid", {255'd0, pcm_puf_in_valid}, {255'd0, exp_valid});
      chk("done", {255'd0, done}, {255'd0, exp_done});
      chk("err", {255'd0, err}, {255'd0, exp_err});
      chk("sig_result", sig_result, exp_sig);
      if (exp_valid) begin
        chk("puf_in", pcm_puf_in, exp_puf_in);
        chk("ipid", {252'd0, pcm_ipid_number}, {252'd0, exp_ipid});
      end
    end
  end

  // Bitwise majority over three reads, counted per bit.
  function automatic logic [SIG-1:0] model_vote(input logic [SIG-1:0] a, input logic [SIG-1:0] b,
                                                input logic [SIG-1:0] c);
    logic [SIG-1:0] v;
    int n;
    v = '0;
    for (int i = 0; i < SIG; i++) begin
      n = int'(a[i]) + int'(b[i]) + int'(c[i]);
      v[i] = (n >= 2);
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_busy = 1'b0; exp_req = 1'b0; exp_instr = 2'b00; exp_valid = 1'b0; exp_done = 1'b0;
  endtask

  // One full transaction; ack_delay < 0 or >= TMO means no acknowledge.
  task automatic run_op(input logic [1:0] op_i, input logic [3:0] id_i,
                        input logic [SIG-1:0] r0, input logic [SIG-1:0] r1, input logic [SIG-1:0] r2,
                        input bit gapped, input bit stray, input int ack_delay, input logic [SIG-1:0] ret);
    logic [SIG-1:0] cur;
    int r, w, cyc;
    bit first_gap, acked;
    start = 1'b1; op = op_i; ipid_number = id_i;
    if (stray) begin puf_word_valid = 1'b1; puf_word = $urandom; end
    step();
    exp_busy = 1'b1; exp_req = 1'b1; exp_err = 1'b0;
    r = 0; w = 0; cyc = 0; first_gap = 1'b1;
    while (r < 3) begin
      start = 1'b0; op = op_i;
      if (gapped && cyc[0]) begin
        puf_word_valid = 1'b0; puf_word = $urandom;
        if (first_gap) begin start = 1'b1; op = 2'b11; first_gap = 1'b0; end
      end else begin
        cur = (r == 0) ? r0 : ((r == 1) ? r1 : r2);
        puf_word_valid = 1'b1;
        puf_word = cur[w*WW +: WW];
        w++;
        if (w == NW) begin w = 0; r++; end
      end
      cyc++;
      step();
    end
    start = 1'b0; puf_word_valid = 1'b0;
    exp_req = 1'b0;
    step();
    exp_instr = op_i; exp_valid = 1'b1; exp_puf_in = model_vote(r0, r1, r2); exp_ipid = id_i;
    acked = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      pcm_S_c = 1'b0; pcm_puf_out_valid = 1'b0; pcm_puf_out = ~ret;
      if (k == ack_delay) begin
        acked = 1'b1;
        pcm_S_c = 1'b1; pcm_puf_out_valid = 1'b1;
        if (op_i == 2'b10) pcm_puf_out = ret;
      end else if (k == 0 && ack_delay > 0) begin
        if (op_i == 2'b01) pcm_puf_out_valid = 1'b1; else pcm_S_c = 1'b1;
      end
      if (stray) begin puf_word_valid = k[0]; puf_word = $urandom; end
      step();
      if (acked) break;
    end
    pcm_S_c = 1'b0; pcm_puf_out_valid = 1'b0; puf_word_valid = 1'b0;
    exp_instr = 2'b00;
    if (!acked) exp_err = 1'b1;
    if (acked && op_i == 2'b10) exp_sig = ret;
    step();
    exp_done = 1'b1; exp_valid = 1'b0;
    if (stray) begin puf_word_valid = 1'b1; puf_word = $urandom; end
    step();
    set_idle_exp();
    puf_word_valid = stray;
    step();
    puf_word_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; ipid_number = '0; puf_word = '0;
    puf_word_valid = 1'b0; pcm_S_c = 1'b0; pcm_puf_out = '0; pcm_puf_out_valid = 1'b0;
    set_idle_exp(); exp_err = 1'b0; exp_sig = '0; exp_puf_in = '0; exp_ipid = '0;
    step();
    chk_en = 1'b1;
    start = 1'b1; op = 2'b01; puf_word_valid = 1'b1;
    step();
    start = 1'b0; puf_word_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_puf_in", pcm_puf_in, '0);

    // Steady A5 reads, provision, ID 5, acknowledge on third ISSUE cycle.
    run_op(2'b01, 4'd5, A5, A5, A5, 1'b0, 1'b0, 2, R1);
    chk("lit_a5_puf_in", pcm_puf_in, A5);
    chk("lit_a5_ipid", {252'd0, pcm_ipid_number}, 256'd5);

    // Majority X,X,Y and X,Y,Y.
    run_op(2'b01, 4'd3, X, X, Y, 1'b0, 1'b0, 0, R1);
    chk("lit_xxy", pcm_puf_in, X);
    run_op(2'b10, 4'd9, X, Y, Y, 1'b0, 1'b0, 1, R1);
    chk("lit_xyy", pcm_puf_in, Y);
    chk("lit_sig_r1", sig_result, R1);

    // Back-to-back versus gapped delivery with stray words and a busy start.
    run_op(2'b10, 4'd1, P, ~P, P, 1'b0, 1'b0, 0, R2);
    chk("lit_p_b2b", pcm_puf_in, P);
    run_op(2'b10, 4'd14, P, ~P, P, 1'b1, 1'b1, 3, R2);
    chk("lit_p_gapped", pcm_puf_in, P);
    chk("lit_sig_r2", sig_result, R2);

    // No acknowledge: timeout sets err.
    run_op(2'b01, 4'd6, Y, Y, X, 1'b0, 1'b0, -1, R1);
    chk("lit_tmo_err", {255'd0, err}, 256'd1);
    // Acknowledge on the final allowed cycle; start clears err.
    run_op(2'b10, 4'd15, X, X, X, 1'b0, 1'b0, TMO - 1, R1);
    chk("lit_late_ack_err", {255'd0, err}, 256'd0);
    chk("lit_late_ack_sig", sig_result, R1);

    // Invalid op sets err and stays idle.
    start = 1'b1; op = 2'b11;
    step();
    start = 1'b0; exp_err = 1'b1;
    step();
    step();

    // Reset after 5 words of the second read, then a fresh run.
    start = 1'b1; op = 2'b01; ipid_number = 4'd2;
    step();
    start = 1'b0; exp_busy = 1'b1; exp_req = 1'b1; exp_err = 1'b0;
    for (int i = 0; i < NW + 5; i++) begin
      puf_word_valid = 1'b1; puf_word = '1;
      step();
    end
    puf_word_valid = 1'b0; rst_n = 1'b0;
    step();
    set_idle_exp(); exp_err = 1'b0; exp_sig = '0;
    chk("rst_mid_puf_in", pcm_puf_in, '0);
    rst_n = 1'b1;
    step();
    run_op(2'b01, 4'd7, '0, '0, '1, 1'b0, 1'b0, 0, R1);
    chk("lit_after_rst", pcm_puf_in, '0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
